// File: rtl/mac_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer_pkg
//  Purpose  : Shared types and constants for the Horner MAC sequencer:
//             FSM state encoding, IEEE-754 zero word, default datapath
//             latencies.
//  Revision : 1.0 - initial release
// ============================================================================
package mac_sequencer_pkg;

    // Sequencer states, 3-bit encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LD_S   = 3'd1,
        WAIT_M = 3'd2,
        LD_C   = 3'd3,
        WAIT_A = 3'd4,
        DONE   = 3'd5
    } state_t;

    // +0.0 in single precision; first Horner multiplicand
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    // Latencies of the stock MAC datapath
    localparam int c_default_mul_lat = 2;
    localparam int c_default_add_lat = 2;

endpackage : mac_sequencer_pkg
`default_nettype wire

// File: rtl/mac_sequencer_coeff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer_coeff_bank
//  Purpose  : coeff_bank - 16 x WIDTH coefficient register file with
//             synchronous write and combinational read.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer_coeff_bank
    import mac_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_n,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [3:0]       i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [3:0]       i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int c_depth = 16;

    logic [WIDTH-1:0] r_mem [c_depth];

    // Clear every coefficient on reset, otherwise accept qualified writes
    always_ff @(posedge clk_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= WIDTH'(FP_ZERO);
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : mac_sequencer_coeff_bank
`default_nettype wire

// File: rtl/mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mac_sequencer
//  Purpose  : Evaluates p(x) = sum c_k * x^k by Horner steps on an external
//             MAC datapath. Each step loads the multiplicand (0 first, then
//             x), waits MUL_LAT, loads coefficient c_j (j = DEGREE down to
//             0), waits ADD_LAT. The final adder output is the result.
//  Revision : 1.0 - initial release
// ============================================================================
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEGREE  = 4,
    parameter int MUL_LAT = c_default_mul_lat,
    parameter int ADD_LAT = c_default_add_lat
) (
    input  logic             clk_n,
    input  logic             rst_n,
    input  logic             cw_en,
    input  logic [3:0]       cw_addr,
    input  logic [WIDTH-1:0] cw_data,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [WIDTH-1:0] x_data,
    output logic             y_valid,
    input  logic             y_ready,
    output logic [WIDTH-1:0] y_data,
    output logic [WIDTH-1:0] dp_signal,
    output logic [WIDTH-1:0] dp_coeff,
    output logic             dp_LD_signal,
    output logic             dp_LD_coeff,
    input  logic [WIDTH-1:0] dp_result,
    output logic             busy
);

    localparam int c_max_lat = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int c_cnt_w   = $clog2(c_max_lat + 1);
    localparam int c_step_w  = 5;

    localparam logic [c_cnt_w-1:0]  c_mul_cnt  = c_cnt_w'(MUL_LAT);
    localparam logic [c_cnt_w-1:0]  c_add_cnt  = c_cnt_w'(ADD_LAT);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_step_w-1:0] c_steps    = c_step_w'(DEGREE + 1);
    localparam logic [c_step_w-1:0] c_step_one = c_step_w'(1);
    localparam logic [3:0]          c_max_addr = 4'(DEGREE);

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_x;
    logic [WIDTH-1:0]    r_y;
    logic [c_step_w-1:0] r_step;     // Horner steps not yet loaded into the adder
    logic [c_cnt_w-1:0]  r_cnt;      // wait-state down-counter
    logic                w_coef_we;
    logic [3:0]          w_coef_raddr;
    logic [WIDTH-1:0]    w_coef_rdata;
    logic                w_first_step;
    logic                w_wait_end;

    // Coefficients may only change while no evaluation is in flight
    assign w_coef_we    = cw_en && (r_state == IDLE) && (cw_addr <= c_max_addr);
    // The coefficient for the current step is c_(remaining-1)
    assign w_coef_raddr = 4'(r_step - c_step_one);
    assign w_first_step = (r_step == c_steps);
    assign w_wait_end   = (r_cnt == c_cnt_one);

    mac_sequencer_coeff_bank #(
        .WIDTH (WIDTH)
    ) u_coeff_bank (
        .clk_n   (clk_n),
        .rst_n   (rst_n),
        .i_we    (w_coef_we),
        .i_waddr (cw_addr),
        .i_wdata (cw_data),
        .i_raddr (w_coef_raddr),
        .o_rdata (w_coef_rdata)
    );

    // State register
    always_ff @(posedge clk_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (x_valid) w_state_next = LD_S;
            LD_S:    w_state_next = WAIT_M;
            WAIT_M:  if (w_wait_end) w_state_next = LD_C;
            LD_C:    w_state_next = WAIT_A;
            WAIT_A:  if (w_wait_end) w_state_next = (r_step == '0) ? DONE : LD_S;
            DONE:    if (y_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture, step/wait counters and result capture
    always_ff @(posedge clk_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_step <= '0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (x_valid) begin
                        r_x    <= x_data;
                        r_step <= c_steps;
                    end
                end
                LD_S:   r_cnt <= c_mul_cnt;
                WAIT_M: r_cnt <= r_cnt - c_cnt_one;
                LD_C: begin
                    r_cnt  <= c_add_cnt;
                    r_step <= r_step - c_step_one;
                end
                WAIT_A: begin
                    r_cnt <= r_cnt - c_cnt_one;
                    if (w_wait_end && (r_step == '0)) begin
                        r_y <= dp_result;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath strobes; data buses are forced to zero outside their strobe
    always_comb begin
        dp_LD_signal = 1'b0;
        dp_LD_coeff  = 1'b0;
        dp_signal    = '0;
        dp_coeff     = '0;
        case (r_state)
            LD_S: begin
                dp_LD_signal = 1'b1;
                dp_signal    = w_first_step ? WIDTH'(FP_ZERO) : r_x;
            end
            LD_C: begin
                dp_LD_coeff = 1'b1;
                dp_coeff    = w_coef_rdata;
            end
            default: ;
        endcase
    end

    assign busy    = (r_state != IDLE);
    assign x_ready = (r_state == IDLE);
    assign y_valid = (r_state == DONE);
    assign y_data  = r_y;

endmodule : mac_sequencer
`default_nettype wire

// File: tb/tb_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mac_sequencer
//  Purpose  : Self-checking bench for mac_sequencer. Contains an integer
//             model of the MAC datapath and a polynomial reference model
//             (direct power sum) compared against the DUT every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mac_sequencer;

    localparam int WIDTH   = 32;
    localparam int DEGREE  = 4;
    localparam int MUL_LAT = 2;
    localparam int ADD_LAT = 2;
    localparam int LAT     = (DEGREE + 1) * (2 + MUL_LAT + ADD_LAT) + 1;

    localparam logic [31:0] FP_1 = 32'h3F80_0000;
    localparam logic [31:0] FP_2 = 32'h4000_0000;
    localparam logic [31:0] FP_3 = 32'h4040_0000;
    localparam logic [31:0] FP_5 = 32'h40A0_0000;

    logic        clk_n   = 1'b0;
    logic        rst_n   = 1'b0;
    logic        cw_en   = 1'b0;
    logic [3:0]  cw_addr = 4'd0;
    logic [31:0] cw_data = 32'h0;
    logic        x_valid = 1'b0;
    logic [31:0] x_data  = 32'h0;
    logic        y_ready = 1'b0;
    logic        x_ready, y_valid, busy, dp_LD_signal, dp_LD_coeff;
    logic [31:0] y_data, dp_signal, dp_coeff, dp_result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_n = ~clk_n;

    mac_sequencer #(
        .WIDTH   (WIDTH),
        .DEGREE  (DEGREE),
        .MUL_LAT (MUL_LAT),
        .ADD_LAT (ADD_LAT)
    ) dut (
        .clk_n        (clk_n),
        .rst_n        (rst_n),
        .cw_en        (cw_en),
        .cw_addr      (cw_addr),
        .cw_data      (cw_data),
        .x_valid      (x_valid),
        .x_ready      (x_ready),
        .x_data       (x_data),
        .y_valid      (y_valid),
        .y_ready      (y_ready),
        .y_data       (y_data),
        .dp_signal    (dp_signal),
        .dp_coeff     (dp_coeff),
        .dp_LD_signal (dp_LD_signal),
        .dp_LD_coeff  (dp_LD_coeff),
        .dp_result    (dp_result),
        .busy         (busy)
    );

    // ---------------- integer <-> single-precision helpers ----------------
    function automatic int sp_to_int(input logic [31:0] b);
        int e;
        int v;
        e = int'(b[30:23]);
        if (e == 0) return 0;
        v = int'({8'd0, 1'b1, b[22:0]});
        if (e >= 150) v = v <<< (e - 150);
        else          v = v >>> (150 - e);
        return b[31] ? -v : v;
    endfunction

    function automatic logic [31:0] int_to_sp(input int v);
        logic [31:0] mag;
        logic [31:0] m;
        int p;
        if (v == 0) return 32'h0;
        mag = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) p = i;
        if (p >= 23) m = mag >> (p - 23);
        else         m = mag << (23 - p);
        return {(v < 0), 8'(127 + p), m[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- MAC datapath model (integer valued) ----------------
    int          bdp_prod = 0;
    int          bdp_acc  = 7;   // stale accumulator: only a zero first multiplicand clears it
    int          bdp_sum;
    logic [31:0] bdp_pipe [ADD_LAT];
    logic        bdp_vld  [ADD_LAT];

    // Multiplier latches signal*acc; adder result emerges ADD_LAT cycles after LD_coeff
    always @(posedge clk_n) begin
        if (dp_LD_signal === 1'b1) bdp_prod <= sp_to_int(dp_signal) * bdp_acc;
        if (dp_LD_coeff === 1'b1) begin
            bdp_sum = bdp_prod + sp_to_int(dp_coeff);
            bdp_acc     <= bdp_sum;
            bdp_pipe[0] <= int_to_sp(bdp_sum);
        end
        bdp_vld[0] <= (dp_LD_coeff === 1'b1);
        for (int i = 1; i < ADD_LAT; i++) begin
            bdp_pipe[i] <= bdp_pipe[i-1];
            bdp_vld[i]  <= bdp_vld[i-1];
        end
    end

    // Outside the valid window the adder shows an obviously wrong word
    assign dp_result = (bdp_vld[ADD_LAT-1] === 1'b1) ? bdp_pipe[ADD_LAT-1] : 32'hFFFF_FFFF;

    // ---------------- behavioural reference model ----------------
    int          m_state = 0;   // 0 idle, 1 evaluating, 2 result held
    int          m_cnt   = 0;
    bit          m_live  = 1'b0;
    logic [31:0] m_y     = 32'h0;
    logic [31:0] m_coef [16];

    function automatic int poly(input int x);
        int acc;
        int pw;
        acc = 0;
        pw  = 1;
        for (int k = 0; k <= DEGREE; k++) begin
            acc += sp_to_int(m_coef[k]) * pw;
            pw  *= x;
        end
        return acc;
    endfunction

    // Model update: handshake rules and fixed evaluation latency
    always @(posedge clk_n) begin
        if (!rst_n) begin
            m_state = 0;
            m_cnt   = 0;
            m_live  = 1'b1;
            for (int k = 0; k < 16; k++) m_coef[k] = 32'h0;
        end else begin
            case (m_state)
                0: begin
                    if (cw_en && (int'(cw_addr) <= DEGREE)) m_coef[cw_addr] = cw_data;
                    if (x_valid) begin
                        m_y     = int_to_sp(poly(sp_to_int(x_data)));
                        m_cnt   = LAT - 1;
                        m_state = 1;
                    end
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_state = 2;
                end
                default: if (y_ready) m_state = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    int n_ls = 0;
    int n_lc = 0;
    bit strobes_checked = 1'b0;

    // Compare every DUT output with the model on the falling edge
    always @(negedge clk_n) begin
        if (m_live) begin
            check("y_valid", {31'd0, y_valid}, {31'd0, (m_state == 2)});
            if (m_state == 2) check("y_data", y_data, m_y);
            check("busy", {31'd0, busy}, {31'd0, (m_state != 0)});
            check("x_ready", {31'd0, x_ready}, {31'd0, (m_state == 0)});
            check("strobe_overlap", {31'd0, dp_LD_signal & dp_LD_coeff}, 32'd0);
            if (!dp_LD_signal) check("dp_signal_idle", dp_signal, 32'h0);
            if (!dp_LD_coeff)  check("dp_coeff_idle", dp_coeff, 32'h0);
            if (m_state == 0) begin
                n_ls = 0;
                n_lc = 0;
                strobes_checked = 1'b0;
            end else if (m_state == 1) begin
                n_ls += int'(dp_LD_signal);
                n_lc += int'(dp_LD_coeff);
            end else if (!strobes_checked) begin
                check("ld_signal_count", n_ls, DEGREE + 1);
                check("ld_coeff_count", n_lc, DEGREE + 1);
                strobes_checked = 1'b1;
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic write_coef(input logic [3:0] a, input logic [31:0] d);
        cw_en = 1'b1;
        cw_addr = a;
        cw_data = d;
        @(posedge clk_n); #1;
        cw_en = 1'b0;
    endtask

    // Called #1 after the accepting edge: waits for y_valid, holds, handshakes
    task automatic finish_eval(input int hold, input bit poke, output int lat,
                               output logic [31:0] y_first, output logic [31:0] y_last);
        lat = 0;
        while (lat < 200) begin
            @(negedge clk_n);
            lat++;
            if (y_valid) break;
            if (poke && lat == 5) begin
                cw_en = 1'b1; cw_addr = 4'd0; cw_data = FP_5;
                @(posedge clk_n); #1;
                cw_en = 1'b0;
            end
        end
        y_first = y_data;
        y_last  = y_data;
        if (!y_valid) begin
            check("y_valid_timeout", {31'd0, y_valid}, 32'd1);
            return;
        end
        if (poke) x_valid = 1'b1;
        repeat (hold) @(posedge clk_n);
        #1;
        y_last = y_data;
        if (hold > 0) check("x_ready_while_held", {31'd0, x_ready}, 32'd0);
        y_ready = 1'b1;
        @(posedge clk_n); #1;
        y_ready = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic run_eval(input logic [31:0] x, input int hold, input bit poke, output int lat,
                            output logic [31:0] y_first, output logic [31:0] y_last);
        x_valid = 1'b1;
        x_data  = x;
        @(posedge clk_n); #1;
        x_valid = 1'b0;
        finish_eval(hold, poke, lat, y_first, y_last);
    endtask

    // ---------------- main sequence ----------------
    int          lat;
    logic [31:0] yf, yl;

    initial begin
        repeat (3) @(posedge clk_n);
        #1 rst_n = 1'b1;
        @(negedge clk_n);
        check("reset_y_valid", {31'd0, y_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_x_ready", {31'd0, x_ready}, 32'd1);
        check("reset_y_data", y_data, 32'h0);
        check("reset_ld_signal", {31'd0, dp_LD_signal}, 32'd0);
        check("reset_ld_coeff", {31'd0, dp_LD_coeff}, 32'd0);

        // All-ones polynomial at x=2: 31.0 after 31 cycles
        for (int k = 0; k <= DEGREE; k++) write_coef(4'(k), FP_1);
        run_eval(FP_2, 0, 1'b0, lat, yf, yl);
        check("ones_latency", lat, 31);
        check("ones_result", yf, 32'h41F8_0000);
        check("model_pin_31", m_y, 32'h41F8_0000);

        // c0=3, x=0 returns c0 exactly
        write_coef(4'd0, FP_3);
        run_eval(32'h0, 0, 1'b0, lat, yf, yl);
        check("xzero_result", yf, 32'h4040_0000);

        // Result held for 10 cycles with a competing x_valid that must be ignored
        write_coef(4'd0, FP_1);
        run_eval(FP_2, 10, 1'b1, lat, yf, yl);
        check("held_first", yf, 32'h41F8_0000);
        check("held_last", yl, 32'h41F8_0000);
        check("no_accept_in_done", {31'd0, busy}, 32'd0);

        // Dropped writes: out-of-range address in IDLE, c0 write while busy
        write_coef(4'd9, FP_5);
        run_eval(FP_2, 0, 1'b1, lat, yf, yl);
        check("dropped_writes_result", yf, 32'h41F8_0000);

        // Same-cycle write and accept: c4=3.0, x=1.0 gives 7.0
        x_valid = 1'b1; x_data = FP_1;
        cw_en = 1'b1; cw_addr = 4'd4; cw_data = FP_3;
        @(posedge clk_n); #1;
        x_valid = 1'b0; cw_en = 1'b0;
        finish_eval(0, 1'b0, lat, yf, yl);
        check("same_cycle_write", yf, 32'h40E0_0000);

        // Reset in cycle 12 of an evaluation
        x_valid = 1'b1; x_data = FP_2;
        @(posedge clk_n); #1;
        x_valid = 1'b0;
        repeat (12) @(negedge clk_n);
        rst_n = 1'b0;
        @(posedge clk_n); #1;
        rst_n = 1'b1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_x_ready", {31'd0, x_ready}, 32'd1);
        check("abort_y_valid", {31'd0, y_valid}, 32'd0);
        check("abort_y_data", y_data, 32'h0);
        run_eval(FP_2, 0, 1'b0, lat, yf, yl);
        check("cleared_coef_result", yf, 32'h0);

        // Randomised traffic against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk_n); #1;
            rst_n   = ($urandom_range(599) != 0);
            cw_en   = ($urandom_range(3) == 0);
            cw_addr = ($urandom_range(3) != 0) ? 4'($urandom_range(DEGREE)) : 4'($urandom_range(15));
            cw_data = int_to_sp(int'($urandom_range(10)) - 5);
            x_valid = ($urandom_range(3) == 0);
            x_data  = int_to_sp(int'($urandom_range(6)) - 3);
            y_ready = ($urandom_range(1) == 1);
        end
        @(posedge clk_n); #1;
        rst_n = 1'b1; cw_en = 1'b0; x_valid = 1'b0; y_ready = 1'b1;
        repeat (LAT + 5) @(posedge clk_n);
        #1;
        check("drain_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mac_sequencer
`default_nettype wire

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, IEEE-754 single-precision word width.
REQ-002 SHALL have parameter DEGREE, default 4, polynomial degree; legal range 1..15.
REQ-003 SHALL have parameter MUL_LAT, default 2, datapath multiplier latency in cycles (>=1).
REQ-004 SHALL have parameter ADD_LAT, default 2, datapath adder latency in cycles (>=1).
REQ-005 SHALL have one clock and a synchronous, active-low reset: clk_n input 1 (all state updates on its rising edge); rst_n input 1 (synchronous, active low).
REQ-006 SHALL have the coefficient write port: cw_en input 1 (write strobe), cw_addr input 4 (coefficient index k), cw_data input WIDTH (c_k).
REQ-007 SHALL have the operand port: x_valid input 1, x_ready output 1, x_data input WIDTH (evaluation point x).
REQ-008 SHALL have the result port: y_valid output 1, y_ready input 1, y_data output WIDTH (p(x)).
REQ-009 SHALL have the datapath drive port: dp_signal output WIDTH, dp_coeff output WIDTH, dp_LD_signal output 1, dp_LD_coeff output 1, dp_result input WIDTH.
REQ-010 SHALL have busy output 1, high in every state except IDLE.

Function
REQ-011 SHALL evaluate p(x)=sum c_k*x^k by Horner steps on the attached MAC datapath (multiply output registered on LD_coeff and added to coeff; add output registered on LD_signal and multiplied by signal).
REQ-012 SHALL implement FSM states IDLE, LD_S, WAIT_M, LD_C, WAIT_A, DONE.
REQ-013 SHALL go IDLE->LD_S on the cycle x_valid&&x_ready; x_data captured into an internal x register on that edge; step index set to DEGREE+1.
REQ-014 LD_S SHALL last 1 cycle with dp_LD_signal=1; dp_signal = 0x00000000 on the first step, x register otherwise; then WAIT_M.
REQ-015 WAIT_M SHALL last exactly MUL_LAT cycles (down-counter), then LD_C.
REQ-016 LD_C SHALL last 1 cycle with dp_LD_coeff=1, dp_coeff = c_j where j = DEGREE on the first step, decrementing by 1 per step; then WAIT_A.
REQ-017 WAIT_A SHALL last exactly ADD_LAT cycles; then LD_S if steps remain, else DONE with y_data <= dp_result on that transition edge.
REQ-018 dp_LD_signal and dp_LD_coeff SHALL never be high in the same cycle; dp_signal/dp_coeff SHALL be 0 when their strobe is low.
REQ-019 Latency from accepting edge to first y_valid cycle SHALL be (DEGREE+1)*(2+MUL_LAT+ADD_LAT)+1 cycles (31 at defaults).
REQ-020 DONE SHALL hold y_valid=1 and y_data stable until y_ready=1; on that edge go IDLE.
REQ-021 x_ready SHALL equal (state==IDLE); x_valid in DONE SHALL not be accepted, even with y_ready high the same cycle.
REQ-022 cw_en SHALL write c[cw_addr] only in IDLE and only when cw_addr<=DEGREE; otherwise the write is dropped silently.
REQ-023 cw_en and x_valid in the same IDLE cycle SHALL both take effect; the evaluation uses the written value.

Reset
REQ-024 On rst_n=0 at a clock edge: state IDLE, all coefficients 0, x register 0, counters 0, y_data 0, y_valid 0, dp_LD_signal 0, dp_LD_coeff 0, busy 0, x_ready 1 in the next cycle.
REQ-025 Reset mid-operation SHALL abandon the evaluation with no y_valid pulse.

Structure
REQ-026 Shared package SHALL hold the FSM state enum, FP_ZERO constant, and default MUL_LAT/ADD_LAT values.
REQ-027 Coefficient storage SHALL be one sub-module, coeff_bank (16xWIDTH registers, synchronous write, combinational read).

Verification
REQ-028 c0..c4=1.0 (0x3F800000), x=2.0 (0x40000000) -> y_data=0x41F80000 (31.0), y_valid exactly 31 cycles after accept.
REQ-029 c0=3.0 (0x40400000), c1..c4=1.0, x=0.0 -> y_data=0x40400000.
REQ-030 y_ready held low 10 cycles after y_valid -> y_data/y_valid stable, x_ready=0, second x_valid not accepted until after handshake.
REQ-031 cw_en with cw_addr=0, data 5.0 while busy and cw_addr=9 in IDLE -> coefficients unchanged, result identical to REQ-028 rerun.
REQ-032 rst_n low at cycle 12 of an evaluation -> next cycle IDLE, no y_valid, coefficients 0; new x=2.0 -> y_data=0x00000000.
REQ-033 Every cycle: dp_LD_signal and dp_LD_coeff never both high; strobe count per evaluation = DEGREE+1 each.
